dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate data cache sitting in the MEM stage of the RISC-V pipeline, between the data-memory port and the backing memory. It produces DCacheMiss for the hazard unit, which stalls the pipeline while the cache writes back and refills a line. Hits complete in the same cycle, so the MEM-stage timing of a hit matches a plain data RAM.

Parameters:
SETS, 64, number of lines; power of two, 2..1024.
LINE_WORDS, 4, 32-bit words per line; power of two, 1..16.
MEM_AW, 32, byte-address width.

Ports:
clk  in  1  clock, rising edge.
CpuRst  in  1  synchronous active-high reset.
rd_req  in  1  load request from MEM stage.
wr_req  in  1  store request from MEM stage; rd_req and wr_req are never both 1.
addr  in  MEM_AW  byte address; bits[1:0] are ignored for indexing.
wr_be  in  4  byte enables for a store.
wr_data  in  32  store data, already lane-aligned.
rd_data  out  32  load data; valid when rd_req=1 and DCacheMiss=0.
DCacheMiss  out  1  stall request to the hazard unit.
mem_req  out  1  word-transfer request to backing memory.
mem_we  out  1  1 = write, 0 = read.
mem_addr  out  MEM_AW  word-aligned byte address.
mem_wdata  out  32  writeback data.
mem_rdata  in  32  refill data.
mem_ack  in  1  one-cycle completion pulse per word.

Behaviour:
- Address split: offset = addr[log2(LINE_WORDS)+1:2]; index = next log2(SETS) bits; tag = remaining upper bits.
- Per-line state: valid, dirty, tag, and LINE_WORDS data words, held in registers or distributed RAM with asynchronous read.
- hit = valid[index] and (tag match).
- DCacheMiss = (rd_req or wr_req) and (state != IDLE or not hit). It is combinational.
- Load hit: rd_data = line word, available in the same cycle. rd_data = 0 when not hitting.
- Store hit: the enabled bytes are written at the clock edge, and dirty is set.
- FSM states: IDLE, WB, FILL.
  - IDLE, on a miss: go to WB if the victim line is valid and dirty; otherwise go to FILL.
  - WB: issues LINE_WORDS writes of the victim line at address {victim_tag, index, word, 2'b00}, for word 0..N-1. Go to FILL after the last mem_ack.
  - FILL: issues LINE_WORDS reads at {tag, index, word, 2'b00}. Each mem_rdata is written to its word on mem_ack. After the last ack: valid=1, dirty=0, tag updated, return to IDLE.
- The next cycle in IDLE re-evaluates the still-stalled request as a hit, so it completes as in the hit case; a store then sets dirty.
- Memory handshake:
  - mem_req is held at 1 with stable mem_we, mem_addr and mem_wdata until mem_ack.
  - mem_req drops for at least 0 cycles: back-to-back words are allowed, with the next word's address presented in the cycle after the ack.
  - Only one word is outstanding at a time.
  - mem_ack while mem_req=0 is ignored.
- The miss address and tag are latched on IDLE exit. Request inputs are held by the pipeline stall but are not relied on during WB/FILL.
- Word counter: log2(LINE_WORDS) bits, reset to 0 on entry to WB and to FILL, and wraps to 0 after the last word.
- Reset (CpuRst=1 at a clock edge), including mid-WB or mid-FILL:
  - state=IDLE, all valid=0, dirty=0, counter=0, mem_req=0 from that edge onward.
  - Dirty data is discarded.
  - Outputs after reset: DCacheMiss=0 with no request, rd_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- No request while IDLE: the cache holds state and never initiates memory traffic.

Optional Feature:
DCACHE_STATS_EN:
- When defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments once per request completed in IDLE without a miss.
  - miss_cnt increments once per IDLE→WB or IDLE→FILL transition.
  - Both wrap at 2^32 and clear on CpuRst.
- When not defined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg holds:
  - localparams for offset, index and tag widths derived from SETS and LINE_WORDS;
  - the FSM state enum (IDLE, WB, FILL);
  - the address-split helper functions.
- One sub-module, dcache_line_store, holds the tag/valid/dirty/data arrays. It has async read, a byte-enabled word write port, and a line-metadata update port.

Test Plan:
1. After reset, load 0x0000_0100 → DCacheMiss=1, FILL issues reads 0x100, 0x104, 0x108, 0x10C with no WB; after the 4th ack, rd_data = the mem word at 0x100 and DCacheMiss=0 next cycle.
2. Store 0xDEADBEEF, be=4'b0011 to 0x104 (hit) → no memory traffic; a following load of 0x104 returns {old[31:16], 16'hBEEF}.
3. Load 0x0000_0500 (same index, different tag, dirty victim) → 4 writes to 0x100..0x10C carrying the line data, then 4 reads at 0x500..0x50C, then a hit.
4. mem_ack delayed 5 cycles per word → mem_req/mem_addr stay stable, DCacheMiss stays 1 for the whole refill, no word is skipped or duplicated.
5. Assert CpuRst during the 2nd FILL word → mem_req=0 next cycle; re-access of 0x100 misses again with a clean fill and no WB.
6. With DCACHE_STATS_EN: 3 hits + 2 misses → hit_cnt=3 (counting post-fill completions), miss_cnt=2.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the direct-mapped write-back data cache.
//   - default geometry and the offset/index/tag widths derived from it
//   - width helpers usable with any SETS / LINE_WORDS / MEM_AW
//   - FSM state enum (IDLE, WB, FILL)
//   - address-split helpers (word offset, set index, tag)
package dcache_pkg;

   localparam int unsigned SetsDflt      = 64;
   localparam int unsigned LineWordsDflt = 4;
   localparam int unsigned MemAwDflt     = 32;

   function automatic int unsigned off_width(int unsigned line_words);
      return $clog2(line_words);
   endfunction

   function automatic int unsigned idx_width(int unsigned sets);
      return $clog2(sets);
   endfunction

   function automatic int unsigned tag_width(int unsigned mem_aw, int unsigned sets,
                                             int unsigned line_words);
      return mem_aw - 2 - off_width(line_words) - idx_width(sets);
   endfunction

   // A one-word line has no offset field, but signals still need one bit.
   function automatic int unsigned min1(int unsigned w);
      return (w == 0) ? 1 : w;
   endfunction

   localparam int unsigned DfltOffW = off_width(LineWordsDflt);
   localparam int unsigned DfltIdxW = idx_width(SetsDflt);
   localparam int unsigned DfltTagW = tag_width(MemAwDflt, SetsDflt, LineWordsDflt);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB   = 2'd1,
      FILL = 2'd2
   } dc_state_e;

   function automatic logic [63:0] addr_field(logic [63:0] a, int unsigned lsb, int unsigned w);
      logic [63:0] mask;
      mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      return (a >> lsb) & mask;
   endfunction

   function automatic logic [63:0] get_offset(logic [63:0] a, int unsigned line_words);
      return addr_field(a, 2, off_width(line_words));
   endfunction

   function automatic logic [63:0] get_index(logic [63:0] a, int unsigned sets,
                                             int unsigned line_words);
      return addr_field(a, 2 + off_width(line_words), idx_width(sets));
   endfunction

   function automatic logic [63:0] get_tag(logic [63:0] a, int unsigned mem_aw,
                                           int unsigned sets, int unsigned line_words);
      return addr_field(a, 2 + off_width(line_words) + idx_width(sets),
                        tag_width(mem_aw, sets, line_words));
   endfunction

endpackage

// File: rtl/dcache_if.sv
// dcache_if: word-transfer bus between the data cache and backing memory.
//   master (cache): mem_req, mem_we, mem_addr, mem_wdata out; mem_rdata, mem_ack in
//   slave (memory): the reverse
// One word is outstanding at a time; mem_ack is a one-cycle completion pulse.
interface dcache_if import dcache_pkg::*; #(
   parameter int unsigned MEM_AW = MemAwDflt
) ();
   logic              mem_req;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/dcache_line_store.sv
// dcache_line_store: valid/dirty/tag/data arrays of the direct-mapped cache.
//   clk_i, rst_i     : clock, synchronous active-high reset (clears valid and dirty only)
//   rd_*             : asynchronous read of one line's metadata and one word
//   wr_*             : byte-enabled single-word write
//   meta_*           : line metadata update (valid, dirty, tag)
module dcache_line_store import dcache_pkg::*; #(
   parameter int unsigned Sets      = SetsDflt,
   parameter int unsigned LineWords = LineWordsDflt,
   parameter int unsigned IdxW      = DfltIdxW,
   parameter int unsigned OffW      = min1(DfltOffW),
   parameter int unsigned TagW      = DfltTagW
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [IdxW-1:0] rd_idx_i,
   input  logic [OffW-1:0] rd_off_i,
   output logic            rd_valid_o,
   output logic            rd_dirty_o,
   output logic [TagW-1:0] rd_tag_o,
   output logic [31:0]     rd_word_o,
   input  logic            wr_en_i,
   input  logic [IdxW-1:0] wr_idx_i,
   input  logic [OffW-1:0] wr_off_i,
   input  logic [3:0]      wr_be_i,
   input  logic [31:0]     wr_data_i,
   input  logic            meta_en_i,
   input  logic [IdxW-1:0] meta_idx_i,
   input  logic            meta_valid_i,
   input  logic            meta_dirty_i,
   input  logic [TagW-1:0] meta_tag_i
);
   logic [Sets-1:0] valid_q, valid_d;
   logic [Sets-1:0] dirty_q, dirty_d;
   logic [TagW-1:0] tag_q  [Sets];
   logic [31:0]     data_q [Sets][LineWords];

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_dirty_o = dirty_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_word_o  = data_q[rd_idx_i][rd_off_i];

   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (meta_en_i) begin
         valid_d[meta_idx_i] = meta_valid_i;
         dirty_d[meta_idx_i] = meta_dirty_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Tags and data need no reset: they are only observed behind a valid bit.
   always_ff @(posedge clk_i) begin
      if (meta_en_i) tag_q[meta_idx_i] <= meta_tag_i;
      if (wr_en_i) begin
         if (wr_be_i[0]) data_q[wr_idx_i][wr_off_i][7:0]   <= wr_data_i[7:0];
         if (wr_be_i[1]) data_q[wr_idx_i][wr_off_i][15:8]  <= wr_data_i[15:8];
         if (wr_be_i[2]) data_q[wr_idx_i][wr_off_i][23:16] <= wr_data_i[23:16];
         if (wr_be_i[3]) data_q[wr_idx_i][wr_off_i][31:24] <= wr_data_i[31:24];
      end
   end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache for the MEM stage.
//   clk, CpuRst        : clock, synchronous active-high reset
//   rd_req, wr_req     : load / store request (mutually exclusive)
//   addr, wr_be, wr_data : byte address, store byte enables, lane-aligned store data
//   rd_data            : load data, valid when rd_req=1 and DCacheMiss=0, else 0
//   DCacheMiss         : combinational stall request to the hazard unit
//   mem_bus            : dcache_if master to backing memory
//   hit_cnt, miss_cnt  : statistics counters, present only with DCACHE_STATS_EN defined
module dcache_ctrl import dcache_pkg::*; #(
   parameter int unsigned SETS       = SetsDflt,
   parameter int unsigned LINE_WORDS = LineWordsDflt,
   parameter int unsigned MEM_AW     = MemAwDflt
) (
   input  logic              clk,
   input  logic              CpuRst,
   input  logic              rd_req,
   input  logic              wr_req,
   input  logic [MEM_AW-1:0] addr,
   input  logic [3:0]        wr_be,
   input  logic [31:0]       wr_data,
   output logic [31:0]       rd_data,
   output logic              DCacheMiss,
`ifdef DCACHE_STATS_EN
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt,
`endif
   dcache_if.master          mem_bus
);
   localparam int unsigned OffW  = off_width(LINE_WORDS);
   localparam int unsigned OffWs = min1(OffW);
   localparam int unsigned IdxW  = idx_width(SETS);
   localparam int unsigned TagW  = tag_width(MEM_AW, SETS, LINE_WORDS);
   localparam logic [OffWs-1:0] LastWord = OffWs'(LINE_WORDS - 1);

   function automatic logic [MEM_AW-1:0] line_addr(logic [TagW-1:0] t, logic [IdxW-1:0] i,
                                                   logic [OffWs-1:0] w);
      return (MEM_AW'(t) << (IdxW + OffW + 2)) | (MEM_AW'(i) << (OffW + 2)) | (MEM_AW'(w) << 2);
   endfunction

   dc_state_e        state_q, state_d;
   logic [OffWs-1:0] cnt_q, cnt_d;
   logic [IdxW-1:0]  miss_idx_q, miss_idx_d;
   logic [TagW-1:0]  miss_tag_q, miss_tag_d;
   logic [TagW-1:0]  victim_tag_q, victim_tag_d;

   logic [OffWs-1:0] req_off, rs_off, wr_off;
   logic [IdxW-1:0]  req_idx, rs_idx, wr_idx, meta_idx;
   logic [TagW-1:0]  req_tag, rs_tag, meta_tag;
   logic             rs_valid, rs_dirty, hit, req, last;
   logic [31:0]      rs_word, wr_word;
   logic [3:0]       wr_be_s;
   logic             wr_en, meta_en, meta_valid, meta_dirty;

   assign req_off = OffWs'(get_offset(64'(addr), LINE_WORDS));
   assign req_idx = IdxW'(get_index(64'(addr), SETS, LINE_WORDS));
   assign req_tag = TagW'(get_tag(64'(addr), MEM_AW, SETS, LINE_WORDS));

   // Outside IDLE the read port follows the latched miss line so WB can stream it out.
   assign rs_idx = (state_q == IDLE) ? req_idx : miss_idx_q;
   assign rs_off = (state_q == IDLE) ? req_off : cnt_q;

   assign req  = rd_req | wr_req;
   assign hit  = rs_valid && (rs_tag == req_tag);
   assign last = (cnt_q == LastWord);

   dcache_line_store #(
      .Sets      (SETS),
      .LineWords (LINE_WORDS),
      .IdxW      (IdxW),
      .OffW      (OffWs),
      .TagW      (TagW)
   ) u_store (
      .clk_i        (clk),
      .rst_i        (CpuRst),
      .rd_idx_i     (rs_idx),
      .rd_off_i     (rs_off),
      .rd_valid_o   (rs_valid),
      .rd_dirty_o   (rs_dirty),
      .rd_tag_o     (rs_tag),
      .rd_word_o    (rs_word),
      .wr_en_i      (wr_en),
      .wr_idx_i     (wr_idx),
      .wr_off_i     (wr_off),
      .wr_be_i      (wr_be_s),
      .wr_data_i    (wr_word),
      .meta_en_i    (meta_en),
      .meta_idx_i   (meta_idx),
      .meta_valid_i (meta_valid),
      .meta_dirty_i (meta_dirty),
      .meta_tag_i   (meta_tag)
   );

   always_comb begin
      state_d            = state_q;
      cnt_d              = cnt_q;
      miss_idx_d         = miss_idx_q;
      miss_tag_d         = miss_tag_q;
      victim_tag_d       = victim_tag_q;
      wr_en              = 1'b0;
      wr_idx             = req_idx;
      wr_off             = req_off;
      wr_be_s            = wr_be;
      wr_word            = wr_data;
      meta_en            = 1'b0;
      meta_idx           = req_idx;
      meta_valid         = 1'b1;
      meta_dirty         = 1'b1;
      meta_tag           = req_tag;
      rd_data            = '0;
      DCacheMiss         = 1'b0;
      mem_bus.mem_req    = 1'b0;
      mem_bus.mem_we     = 1'b0;
      mem_bus.mem_addr   = '0;
      mem_bus.mem_wdata  = '0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  rd_data = rd_req ? rs_word : '0;
                  // Store hit: merge bytes and mark the line dirty in the same edge.
                  wr_en   = wr_req;
                  meta_en = wr_req;
               end else begin
                  DCacheMiss   = 1'b1;
                  miss_idx_d   = req_idx;
                  miss_tag_d   = req_tag;
                  victim_tag_d = rs_tag;
                  cnt_d        = '0;
                  state_d      = (rs_valid && rs_dirty) ? WB : FILL;
               end
            end
         end
         WB: begin
            DCacheMiss        = req;
            mem_bus.mem_req   = 1'b1;
            mem_bus.mem_we    = 1'b1;
            mem_bus.mem_addr  = line_addr(victim_tag_q, miss_idx_q, cnt_q);
            mem_bus.mem_wdata = rs_word;
            if (mem_bus.mem_ack) begin
               cnt_d = last ? '0 : cnt_q + OffWs'(1);
               if (last) state_d = FILL;
            end
         end
         FILL: begin
            DCacheMiss       = req;
            mem_bus.mem_req  = 1'b1;
            mem_bus.mem_addr = line_addr(miss_tag_q, miss_idx_q, cnt_q);
            if (mem_bus.mem_ack) begin
               wr_en   = 1'b1;
               wr_idx  = miss_idx_q;
               wr_off  = cnt_q;
               wr_be_s = 4'hF;
               wr_word = mem_bus.mem_rdata;
               cnt_d   = last ? '0 : cnt_q + OffWs'(1);
               if (last) begin
                  meta_en    = 1'b1;
                  meta_idx   = miss_idx_q;
                  meta_valid = 1'b1;
                  meta_dirty = 1'b0;
                  meta_tag   = miss_tag_q;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (CpuRst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         miss_idx_q   <= '0;
         miss_tag_q   <= '0;
         victim_tag_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         miss_idx_q   <= miss_idx_d;
         miss_tag_q   <= miss_tag_d;
         victim_tag_q <= victim_tag_d;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (state_q == IDLE && req) begin
         if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
         else     miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (CpuRst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: self-checking bench for dcache_ctrl (default geometry: 64 sets x 4 words).
// Expected memory transfers and load data are queued when a request is driven and
// compared when the DUT presents them.
module tb_dcache_ctrl;
   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] data;
   } mem_txn_t;

   logic        clk;
   logic        CpuRst;
   logic        rd_req, wr_req;
   logic [31:0] addr;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        DCacheMiss;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   dcache_if #(.MEM_AW(32)) bus ();

   dcache_ctrl #(
      .SETS       (64),
      .LINE_WORDS (4),
      .MEM_AW     (32)
   ) dut (
      .clk        (clk),
      .CpuRst     (CpuRst),
      .rd_req     (rd_req),
      .wr_req     (wr_req),
      .addr       (addr),
      .wr_be      (wr_be),
      .wr_data    (wr_data),
      .rd_data    (rd_data),
      .DCacheMiss (DCacheMiss),
`ifdef DCACHE_STATS_EN
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt),
`endif
      .mem_bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   mem_txn_t    exp_q[$];
   logic [31:0] rd_q[$];
   logic [31:0] bk[logic [31:0]];
   logic [31:0] ref_img[logic [31:0]];
   bit          m_valid[64];
   bit          m_dirty[64];
   logic [21:0] m_tag[64];
   int unsigned n_cmp, n_err;
   int unsigned ack_delay;
   int unsigned exp_hits, exp_misses;
   bit          spurious;
   bit          exp_miss;

   function automatic logic [31:0] init_val(logic [31:0] a);
      return {a[15:0] ^ 16'h5A3C, a[15:0]};
   endfunction

   function automatic logic [31:0] rd_bk(logic [31:0] a);
      return bk.exists(a) ? bk[a] : init_val(a);
   endfunction

   function automatic logic [31:0] rd_ref(logic [31:0] a);
      return ref_img.exists(a) ? ref_img[a] : init_val(a);
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Backing memory: answers one word at a time after ack_delay waiting cycles.
   initial begin : responder
      int unsigned dly;
      mem_txn_t    t;
      dly           = 0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         bus.mem_ack = 1'b0;
         if (bus.mem_req === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexp_mem_req", 32'(bus.mem_req), 32'd0);
               bus.mem_rdata = rd_bk(bus.mem_addr);
               bus.mem_ack   = 1'b1;
            end else begin
               check("mem_addr", bus.mem_addr, exp_q[0].addr);
               check("mem_we", 32'(bus.mem_we), 32'(exp_q[0].we));
               if (exp_q[0].we) check("mem_wdata", bus.mem_wdata, exp_q[0].data);
               if (dly >= ack_delay) begin
                  t = exp_q.pop_front();
                  if (t.we) bk[bus.mem_addr] = bus.mem_wdata;
                  else      bus.mem_rdata = rd_bk(bus.mem_addr);
                  bus.mem_ack = 1'b1;
                  dly         = 0;
               end else begin
                  dly++;
               end
            end
         end else begin
            dly = 0;
            if (spurious) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = 32'hBAD0_BAD0;
            end
         end
      end
   end

   // Reference: tag model plus the CPU-visible memory image.
   task automatic predict(input bit is_wr, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] d);
      int unsigned idx;
      logic [21:0] tg;
      logic [31:0] wa, nw;
      mem_txn_t    t;
      idx = int'(a[9:4]);
      tg  = a[31:10];
      wa  = {a[31:2], 2'b00};
      if (!(m_valid[idx] && m_tag[idx] == tg)) begin
         exp_miss = 1'b1;
         exp_misses++;
         if (m_valid[idx] && m_dirty[idx]) begin
            for (int w = 0; w < 4; w++) begin
               t.we   = 1'b1;
               t.addr = {m_tag[idx], a[9:4], 2'(w), 2'b00};
               t.data = rd_ref(t.addr);
               exp_q.push_back(t);
            end
         end
         for (int w = 0; w < 4; w++) begin
            t.we   = 1'b0;
            t.addr = {tg, a[9:4], 2'(w), 2'b00};
            t.data = '0;
            exp_q.push_back(t);
         end
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
         m_tag[idx]   = tg;
      end else begin
         exp_miss = 1'b0;
      end
      if (is_wr) begin
         nw = rd_ref(wa);
         for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = d[8*b +: 8];
         ref_img[wa]  = nw;
         m_dirty[idx] = 1'b1;
      end else begin
         rd_q.push_back(rd_ref(wa));
      end
   endtask

   // Called just after a rising edge; returns just after the edge that retires the request.
   task automatic do_access(input bit is_wr, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] d);
      bit          done;
      logic [31:0] er;
      predict(is_wr, a, be, d);
      rd_req  = !is_wr;
      wr_req  = is_wr;
      addr    = a;
      wr_be   = be;
      wr_data = d;
      done    = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk);
         if (c == 0) check("miss_flag", 32'(DCacheMiss), 32'(exp_miss));
         if (DCacheMiss === 1'b0) begin
            done = 1'b1;
            exp_hits++;
            if (!is_wr) begin
               er = rd_q.pop_front();
               check("rd_data", rd_data, er);
            end
         end
      end
      if (!done) check("access_timeout", 32'(done), 32'd1);
      check("mem_drain", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
      rd_req = 1'b0;
      wr_req = 1'b0;
   endtask

   task automatic model_reset();
      exp_q.delete();
      rd_q.delete();
      ref_img = bk;
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      exp_hits   = 0;
      exp_misses = 0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_miss"}, 32'(DCacheMiss), 32'd0);
      check({tag, "_rd_data"}, rd_data, 32'd0);
      check({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
      check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
      check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
      check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit          found;
      logic [31:0] ra;
      n_cmp    = 0;
      n_err    = 0;
      CpuRst   = 1'b1;
      rd_req   = 1'b0;
      wr_req   = 1'b0;
      addr     = '0;
      wr_be    = '0;
      wr_data  = '0;
      spurious = 1'b0;
      ack_delay = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      CpuRst = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk);
      #1;

      // Cold miss: clean fill of 0x100..0x10C, no writeback.
      do_access(1'b0, 32'h0000_0100, 4'h0, 32'h0);
      // Partial store hit, then read back the merged word.
      do_access(1'b1, 32'h0000_0104, 4'b0011, 32'hDEAD_BEEF);
      do_access(1'b0, 32'h0000_0104, 4'h0, 32'h0);
      check("merge_const", rd_ref(32'h104), {init_val(32'h104) >> 16, 16'hBEEF});

      // A stray ack with no request must not disturb the idle cache.
      spurious = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      spurious = 1'b0;
      @(negedge clk);
      check("spur_ack_mem_req", 32'(bus.mem_req), 32'd0);
      @(posedge clk);
      #1;
      do_access(1'b0, 32'h0000_0100, 4'h0, 32'h0);

      // Dirty victim: writeback 0x100.. then fill 0x500.., back-to-back acks.
      do_access(1'b0, 32'h0000_0500, 4'h0, 32'h0);
      do_access(1'b0, 32'h0000_050C, 4'h0, 32'h0);

      // Slow memory: request must hold steady across each wait.
      ack_delay = 5;
      do_access(1'b0, 32'h0000_0900, 4'h0, 32'h0);
      ack_delay = 2;
      do_access(1'b1, 32'h0000_0A08, 4'b1100, 32'h1234_5678);
      do_access(1'b0, 32'h0000_0208, 4'h0, 32'h0);
      do_access(1'b0, 32'h0000_0A08, 4'h0, 32'h0);

      // Reset while the second fill word is outstanding.
      ack_delay = 4;
      predict(1'b0, 32'h0000_0100, 4'h0, 32'h0);
      rd_req = 1'b1;
      addr   = 32'h0000_0100;
      found  = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clk);
         if (bus.mem_req === 1'b1 && bus.mem_we === 1'b0 && bus.mem_addr === 32'h104)
            found = 1'b1;
      end
      check("rst_fill_word2_seen", 32'(found), 32'd1);
      @(posedge clk);
      #1;
      CpuRst = 1'b1;
      rd_req = 1'b0;
      @(posedge clk);
      #1;
      CpuRst = 1'b0;
      model_reset();
      @(negedge clk);
      check_idle_outputs("mid_fill_rst");
      @(posedge clk);
      #1;
      do_access(1'b0, 32'h0000_0100, 4'h0, 32'h0);

      // Mixed traffic over two sets and three tags.
      for (int i = 0; i < 12; i++) begin
         ack_delay = $urandom_range(0, 2);
         ra = ($urandom_range(0, 2) << 10) | (($urandom_range(0, 1) ? 32 : 16) << 4)
              | ($urandom_range(0, 3) << 2);
         if ($urandom_range(0, 1) == 1)
            do_access(1'b1, ra, 4'($urandom_range(1, 15)), $urandom);
         else
            do_access(1'b0, ra, 4'h0, 32'h0);
      end

`ifdef DCACHE_STATS_EN
      @(negedge clk);
      check("hit_cnt", hit_cnt, exp_hits);
      check("miss_cnt", miss_cnt, exp_misses);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
